ex_muldiv_unit: RTL and testbench

Iterative multiply/divide unit for the EX stage (MULT, MULTU, DIV, DIVU). It is the requesting side of the pipeline stall protocol. It drives `EX_requireStall` into `PipelineControl` for as long as an operation is in flight. It consumes `EX_MEM_stall` and `EX_MEM_flush` from `PipelineControl` to decide when its result is taken or discarded. One shift-add or restore-subtract iteration per cycle; HI/LO result held until the EX instruction advances.

---
 rtl/muldiv_pkg.sv | 15 +
 rtl/muldiv_step.sv | 29 ++
 rtl/ex_muldiv_unit.sv | 107 ++++++++++
 tb/tb_ex_muldiv_unit.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared encodings for the EX-stage iterative multiply/divide unit.
package muldiv_pkg;

  localparam logic [1:0] OP_MULTU = 2'b00;
  localparam logic [1:0] OP_MULT  = 2'b01;
  localparam logic [1:0] OP_DIVU  = 2'b10;
  localparam logic [1:0] OP_DIV   = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration: shift-add multiply or restoring divide on a 2*WIDTH accumulator.
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   operand,
  input  logic               is_div,
  output logic [2*WIDTH-1:0] acc_next
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH-1:0] diff;

  always_comb begin
    sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand} : '0);
    rem_sh   = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    // Partial remainder stays below the divisor, so the low WIDTH bits of the difference suffice.
    diff     = rem_sh[WIDTH-1:0] - operand;
    acc_next = {sum, acc[WIDTH-1:1]};
    if (is_div) begin
      if (rem_sh >= {1'b0, operand})
        acc_next = {diff, acc[WIDTH-2:0], 1'b1};
      else
        acc_next = {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/ex_muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU for the EX stage; stalls the pipeline while busy and
// holds HI/LO in DONE until the EX instruction advances.
module ex_muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] srcA,
  input  logic [WIDTH-1:0] srcB,
  input  logic             exHold,
  input  logic             cancel,
  output logic             requireStall,
  output logic             resultValid,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH) + 1;

  state_t             state, state_nx;
  logic [CW-1:0]      count;
  logic [2*WIDTH-1:0] acc, acc_nx, mul_res;
  logic [WIDTH-1:0]   opnd, a_raw, mag_a, mag_b, q_res, r_res;
  logic               is_div, neg_q, neg_r, div_zero, sign_a, sign_b, last;

  assign sign_a = op[0] & srcA[WIDTH-1];
  assign sign_b = op[0] & srcB[WIDTH-1];
  assign mag_a  = sign_a ? -srcA : srcA;
  assign mag_b  = sign_b ? -srcB : srcB;
  assign last   = (count == CW'(WIDTH - 1));

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .acc      (acc),
    .operand  (opnd),
    .is_div   (is_div),
    .acc_next (acc_nx)
  );

  assign mul_res = neg_q ? -acc_nx : acc_nx;
  assign q_res   = neg_q ? -acc_nx[WIDTH-1:0] : acc_nx[WIDTH-1:0];
  assign r_res   = neg_r ? -acc_nx[2*WIDTH-1:WIDTH] : acc_nx[2*WIDTH-1:WIDTH];

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (start)   state_nx = S_BUSY;
      S_BUSY:  if (last)    state_nx = S_DONE;
      S_DONE:  if (!exHold) state_nx = S_IDLE;
      default:              state_nx = S_IDLE;
    endcase
    if (cancel) state_nx = S_IDLE;
  end

  assign requireStall = ~cancel & (((state == S_IDLE) & start) | (state == S_BUSY));
  assign resultValid  = (state == S_DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      count    <= '0;
      acc      <= '0;
      opnd     <= '0;
      a_raw    <= '0;
      is_div   <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      div_zero <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else if (!cancel) begin
      if (state == S_IDLE && start) begin
        // Multiply iterates over the multiplier in acc; divide shifts the dividend out of acc.
        acc      <= {{WIDTH{1'b0}}, (op[1] ? mag_a : mag_b)};
        opnd     <= op[1] ? mag_b : mag_a;
        a_raw    <= srcA;
        is_div   <= op[1];
        neg_q    <= sign_a ^ sign_b;
        neg_r    <= sign_a;
        div_zero <= op[1] & (srcB == '0);
        count    <= '0;
      end else if (state == S_BUSY) begin
        acc   <= acc_nx;
        count <= count + CW'(1);
        if (last) begin
          if (!is_div) begin
            {hi, lo} <= mul_res;
          end else if (div_zero) begin
            hi <= a_raw;
            lo <= '1;
          end else begin
            hi <= r_res;
            lo <= q_res;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed and random checks of ex_muldiv_unit against an arithmetic reference model.
module tb_ex_muldiv_unit;
  import muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        rst, start, exHold, cancel;
  logic [1:0]  op;
  logic [31:0] srcA, srcB;
  logic        requireStall, resultValid;
  logic [31:0] hi, lo;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] exp_hi = '0;
  logic [31:0] exp_lo = '0;

  always #5 clk = ~clk;

  ex_muldiv_unit #(.WIDTH(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .op           (op),
    .srcA         (srcA),
    .srcB         (srcB),
    .exHold       (exHold),
    .cancel       (cancel),
    .requireStall (requireStall),
    .resultValid  (resultValid),
    .hi           (hi),
    .lo           (lo)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  // Reference result as {hi, lo} from plain integer arithmetic.
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a,
                                        input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] res;
    sa = longint'(signed'(a));
    sb = longint'(signed'(b));
    if (o == OP_MULTU) begin
      res = {32'b0, a} * {32'b0, b};
    end else if (o == OP_MULT) begin
      res = 64'(sa * sb);
    end else if (b == 32'd0) begin
      res = {a, 32'hFFFF_FFFF};
    end else if (o == OP_DIVU) begin
      res = {a % b, a / b};
    end else begin
      q   = sa / sb;
      r   = sa % sb;
      res = {r[31:0], q[31:0]};
    end
    return res;
  endfunction

  always @(negedge clk) begin
    if (!rst && resultValid) begin
      chk("model_hi", hi, exp_hi);
      chk("model_lo", lo, exp_lo);
    end
  end

  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input int hold, input bit use_lit,
                        input logic [31:0] lit_hi, input logic [31:0] lit_lo);
    int stalls;
    logic [63:0] m;
    stalls = 0;
    @(posedge clk);
    #1;
    op = o; srcA = a; srcB = b; start = 1'b1; exHold = 1'b0;
    m = model(o, a, b);
    exp_hi = m[63:32];
    exp_lo = m[31:0];
    if (use_lit) begin
      chk("lit_model_hi", m[63:32], lit_hi);
      chk("lit_model_lo", m[31:0], lit_lo);
    end
    for (int i = 0; i < 100 && !resultValid; i++) begin
      @(negedge clk);
      if (requireStall) stalls++;
    end
    chk("done_reached", resultValid, 1);
    chk("stall_cycles", stalls, 33);
    if (use_lit) begin
      chk("lit_dut_hi", hi, lit_hi);
      chk("lit_dut_lo", lo, lit_lo);
    end
    exHold = (hold > 0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_valid", resultValid, 1);
      chk("hold_no_restart", requireStall, 0);
    end
    exHold = 1'b0;
    start  = 1'b0;
    @(negedge clk);
    chk("left_done", resultValid, 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; exHold = 1'b0; cancel = 1'b0;
    op = '0; srcA = '0; srcB = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_stall", requireStall, 0);
    chk("rst_valid", resultValid, 0);
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    rst = 1'b0;

    run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1, 32'hFFFF_FFFE, 32'h0000_0001);
    run_op(OP_MULT,  32'hFFFF_FFFD, 32'd7,         0, 1, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    run_op(OP_MULT,  32'h8000_0000, 32'h8000_0000, 0, 1, 32'h4000_0000, 32'h0000_0000);
    run_op(OP_DIV,   32'hFFFF_FFF9, 32'd2,         0, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op(OP_DIV,   32'd7,         32'hFFFF_FFFE, 0, 1, 32'h0000_0001, 32'hFFFF_FFFD);
    run_op(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 0, 1, 32'h0000_0000, 32'h8000_0000);
    run_op(OP_DIVU,  32'd5,         32'd0,         0, 1, 32'd5,         32'hFFFF_FFFF);
    run_op(OP_DIV,   32'hFFFF_FFF9, 32'd0,         0, 1, 32'hFFFF_FFF9, 32'hFFFF_FFFF);
    run_op(OP_DIVU,  32'd100,       32'd7,         4, 1, 32'd2,         32'd14);

    // Cancel on the tenth BUSY cycle; previous result (100/7) must survive.
    @(posedge clk);
    #1;
    op = OP_DIVU; srcA = 32'd1000; srcB = 32'd3; start = 1'b1;
    repeat (11) @(negedge clk);
    chk("busy_before_cancel", requireStall, 1);
    cancel = 1'b1;
    #1;
    chk("cancel_stall_drop", requireStall, 0);
    @(negedge clk);
    chk("cancel_valid", resultValid, 0);
    chk("cancel_hi_kept", hi, 32'd2);
    chk("cancel_lo_kept", lo, 32'd14);
    cancel = 1'b0;
    start  = 1'b0;

    for (int k = 0; k < 4; k++)
      run_op(2'(k), $urandom, (k == 3) ? $urandom_range(1, 300) : $urandom, 0, 0, '0, '0);

    // Synchronous reset on the fifth BUSY cycle.
    @(posedge clk);
    #1;
    op = OP_MULT; srcA = 32'd123; srcB = 32'd456; start = 1'b1;
    repeat (6) @(negedge clk);
    rst   = 1'b1;
    start = 1'b0;
    @(negedge clk);
    chk("midrst_stall", requireStall, 0);
    chk("midrst_valid", resultValid, 0);
    chk("midrst_hi", hi, 0);
    chk("midrst_lo", lo, 0);
    rst = 1'b0;

    run_op(OP_DIVU, 32'd1000, 32'd3, 0, 1, 32'd1, 32'd333);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
